pattern_loader: RTL and testbench
=================================

Name: pattern_loader

Overview:
- Avalon-MM master that programs the packet classifier's control-register bank from a flat pattern vector.
- On a start pulse it runs a fixed write sequence: disable the classifier, write every pattern word, then re-enable.
- Sits between host/test logic and the classifier's avalon_mm_if slave, so pattern updates are atomic with respect to the enable bit.

Parameters:
- AMM_DWIDTH, 32, Avalon-MM data width and register width.
- REG_DEPTH, 4, number of registers in the slave bank: 1 control register plus REG_DEPTH-1 pattern words.
- AMM_AWIDTH, 2, address width; must satisfy 2**AMM_AWIDTH >= REG_DEPTH.
- TIMEOUT, 255, maximum waitrequest-stall cycles per transfer before the sequence aborts.

Ports:
- clk_i  in  1  clock.
- srst_i  in  1  synchronous reset, active-low (asserted when 0).
- start_i  in  1  begin a load sequence; sampled only in IDLE.
- pattern_i  in  AMM_DWIDTH*(REG_DEPTH-1)  pattern to load; captured on accepted start.
- busy_o  out  1  high from the cycle after accepted start until DONE/ERR exits.
- done_o  out  1  one-cycle pulse on successful completion.
- error_o  out  1  sticky; cleared by the next accepted start or by reset.
- amm_if  master  avalon_mm_if.master  uses address[AMM_AWIDTH], write, writedata[AMM_DWIDTH], read, readdata[AMM_DWIDTH], waitrequest.

Behaviour:
- Register map: address 0 is control, with bit0 = enable and other bits 0. Address k (1..REG_DEPTH-1) holds pattern_i[k*AMM_DWIDTH-1 -: AMM_DWIDTH].
- Reset (srst_i=0): state IDLE; write=0, read=0, address=0, writedata=0, busy_o=0, done_o=0, error_o=0, word counter=0, stall counter=0.
- Reset mid-sequence: the sequence aborts immediately, with no further bus activity, even if a transfer is pending.
- Start: accepted when start_i=1 in IDLE. pattern_i is registered that cycle, error_o clears, and the next cycle enters DIS.
- start_i in any other state is ignored, with no queuing.
- FSM and transitions:
  - IDLE -> DIS on accepted start.
  - DIS: write=1, address=0, writedata=0; -> PAT once waitrequest=0.
  - PAT: write=1, address=cnt, writedata=word[cnt], with cnt running 1..REG_DEPTH-1. cnt increments on each accepted beat; after the beat at cnt=REG_DEPTH-1 -> ENA.
  - ENA: write=1, address=0, writedata=1; -> DONE once accepted (or -> RB, see Optional Feature).
  - DONE: done_o=1 for one cycle -> IDLE.
  - ERR: error_o=1 (sticky) -> IDLE.
- Handshake:
  - A transfer is accepted in the cycle where write (or read) =1 and waitrequest=0.
  - address, writedata and write stay stable while waitrequest=1.
  - write and read are never both 1.
  - Back-to-back writes are allowed: the next beat is driven in the cycle after acceptance.
- Timeout:
  - The stall counter resets on each acceptance and counts cycles with waitrequest=1.
  - On reaching TIMEOUT, write/read drop next cycle and the state becomes ERR.
  - The ENA write is never issued after a timeout, so the classifier stays disabled.
- Latency, zero-wait slave: 1 + REG_DEPTH + 1 cycles from accepted start to done_o (for REG_DEPTH=4: DIS, 3×PAT, ENA, DONE = done_o on cycle 6 after start).
- busy_o=1 exactly in the DIS, PAT, ENA, RB and DONE states.

Optional Feature:
- Macro: PATTERN_LOADER_READBACK_EN.
- Enabled: after ENA the FSM enters RB and reads addresses 1..REG_DEPTH-1.
  - readdata is valid the cycle after read is accepted (fixed latency 1).
  - Each word is compared with the captured pattern. Any mismatch -> ERR after the last read; all match -> DONE.
  - The timeout applies to each read as well.
  - Latency grows by 2*(REG_DEPTH-1) cycles with a zero-wait slave.
- Disabled: RB state and compare logic are absent; ENA -> DONE directly, and read is tied 0.

Decomposition:
- Shared package pattern_loader_pkg holds:
  - state enum (IDLE, DIS, PAT, ENA, RB, DONE, ERR);
  - CTRL_ADDR=0;
  - CTRL_EN_BIT=0;
  - function that slices word k from the flat pattern.
- One sub-module, amm_wr_timeout: a stall counter with clear-on-accept and a timeout flag, reused for reads and writes.

Test Plan:
- Zero-wait slave, REG_DEPTH=4, pattern_i=96'hA1B2C3D4_11223344_DEADBEEF, start pulse -> writes (0,0), (1,DEADBEEF), (2,11223344), (3,A1B2C3D4), (0,1) on consecutive cycles; done_o on cycle 6; busy_o high cycles 1-6.
- waitrequest held 3 cycles on the address 2 write -> address/writedata stay stable for 4 cycles, sequence resumes; done_o delayed by exactly 3 cycles.
- TIMEOUT=8, waitrequest stuck 1 from the address 1 write -> write drops after 8 stall cycles; error_o=1 sticky; no write to address 0 with data 1; next start clears error_o.
- start_i held high during a sequence and srst_i=0 asserted mid-PAT -> second start ignored; reset yields all outputs 0 next cycle with no further bus activity.
- With PATTERN_LOADER_READBACK_EN, slave corrupts the readback of word 2 -> error_o=1 and no done_o. With correct readback -> done_o at cycle 6+6=12.

Source files
------------

// File: rtl/pattern_loader_pkg.sv
// Shared types and helpers for the classifier pattern loader.
// State encoding, control-register layout and flat-pattern word slicing.
package pattern_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DIS,
        PAT,
        ENA,
        RB,
        DONE,
        ERR
    } state_e;

    localparam int CTRL_ADDR   = 0;
    localparam int CTRL_EN_BIT = 0;
    localparam int PAT_MAX_W   = 1024;

    // Word k (1-based) of the flat pattern; callers truncate to their data width.
    function automatic logic [PAT_MAX_W-1:0] pat_word(
        input logic [PAT_MAX_W-1:0] flat,
        input int                   k,
        input int                   dw
    );
        if (k < 1) return '0;
        return flat >> ((k - 1) * dw);
    endfunction

endpackage

// File: rtl/avalon_mm_if.sv
// Minimal Avalon-MM bundle between the pattern loader and the classifier bank.
// Single-beat reads and writes, waitrequest backpressure, fixed read latency.
interface avalon_mm_if #(
    parameter int AMM_DWIDTH = 32,
    parameter int AMM_AWIDTH = 2
);
    logic [AMM_AWIDTH-1:0] address;
    logic                  write;
    logic [AMM_DWIDTH-1:0] writedata;
    logic                  read;
    logic [AMM_DWIDTH-1:0] readdata;
    logic                  waitrequest;

    modport master (
        output address, write, writedata, read,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, write, writedata, read,
        output readdata, waitrequest
    );
endinterface

// File: rtl/amm_wr_timeout.sv
// Per-transfer waitrequest stall counter; cleared on accept or when idle.
// Flags timeout combinationally on the TIMEOUT-th consecutive stalled cycle.
module amm_wr_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic srst_i,
    input  logic req_i,
    input  logic wait_i,
    output logic timeout_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] stall_q, stall_d;
    logic          stalled;

    assign stalled   = req_i & wait_i;
    assign timeout_o = stalled && (stall_q == CW'(TIMEOUT - 1));

    always_comb begin
        stall_d = '0;
        if (stalled) stall_d = stall_q + CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!srst_i) stall_q <= '0;
        else         stall_q <= stall_d;
    end

endmodule

// File: rtl/pattern_loader.sv
// Avalon-MM master: disable classifier, write pattern words, re-enable; 1+REG_DEPTH+1 cycles zero-wait.
// Holds each beat under waitrequest, aborts to ERR on timeout; PATTERN_LOADER_READBACK_EN adds verify reads.
module pattern_loader
    import pattern_loader_pkg::*;
#(
    parameter int AMM_DWIDTH = 32,
    parameter int REG_DEPTH  = 4,
    parameter int AMM_AWIDTH = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic                              clk_i,
    input  logic                              srst_i,
    input  logic                              start_i,
    input  logic [AMM_DWIDTH*(REG_DEPTH-1)-1:0] pattern_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              error_o,
    avalon_mm_if.master                       amm_if
);
    localparam int                    PAT_W    = AMM_DWIDTH * (REG_DEPTH - 1);
    localparam logic [AMM_AWIDTH-1:0] LAST_IDX = AMM_AWIDTH'(REG_DEPTH - 1);

    state_e                state_q, state_d;
    logic [PAT_W-1:0]      pattern_q, pattern_d;
    logic [AMM_AWIDTH-1:0] cnt_q, cnt_d;
    logic                  error_q, error_d;
    logic                  req, accept, timeout;
    logic [AMM_DWIDTH-1:0] cur_word;

    assign req      = amm_if.write | amm_if.read;
    assign accept   = req & ~amm_if.waitrequest;
    assign cur_word = AMM_DWIDTH'(pat_word(PAT_MAX_W'(pattern_q), int'(cnt_q), AMM_DWIDTH));
    assign error_o  = error_q;

    amm_wr_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk_i     (clk_i),
        .srst_i    (srst_i),
        .req_i     (req),
        .wait_i    (amm_if.waitrequest),
        .timeout_o (timeout)
    );

`ifdef PATTERN_LOADER_READBACK_EN
    logic rb_wait_q, rb_wait_d;
    logic mism_q, mism_d;
    logic mism_now;
`else
    logic unused_rdata;
    assign unused_rdata = ^amm_if.readdata;
`endif

    always_comb begin
        state_d            = state_q;
        pattern_d          = pattern_q;
        cnt_d              = cnt_q;
        error_d            = error_q;
        busy_o             = 1'b0;
        done_o             = 1'b0;
        amm_if.write       = 1'b0;
        amm_if.read        = 1'b0;
        amm_if.address     = '0;
        amm_if.writedata   = '0;
`ifdef PATTERN_LOADER_READBACK_EN
        rb_wait_d          = rb_wait_q;
        mism_d             = mism_q;
        mism_now           = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    pattern_d = pattern_i;
                    error_d   = 1'b0;
                    cnt_d     = '0;
                    state_d   = DIS;
                end
            end
            DIS: begin
                busy_o         = 1'b1;
                amm_if.write   = 1'b1;
                amm_if.address = AMM_AWIDTH'(CTRL_ADDR);
                if (accept) begin
                    cnt_d   = AMM_AWIDTH'(1);
                    state_d = PAT;
                end
            end
            PAT: begin
                busy_o           = 1'b1;
                amm_if.write     = 1'b1;
                amm_if.address   = cnt_q;
                amm_if.writedata = cur_word;
                if (accept) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = ENA;
                    end else begin
                        cnt_d = cnt_q + AMM_AWIDTH'(1);
                    end
                end
            end
            ENA: begin
                busy_o           = 1'b1;
                amm_if.write     = 1'b1;
                amm_if.address   = AMM_AWIDTH'(CTRL_ADDR);
                amm_if.writedata = AMM_DWIDTH'(1) << CTRL_EN_BIT;
                if (accept) begin
`ifdef PATTERN_LOADER_READBACK_EN
                    cnt_d     = AMM_AWIDTH'(1);
                    rb_wait_d = 1'b0;
                    mism_d    = 1'b0;
                    state_d   = RB;
`else
                    state_d   = DONE;
`endif
                end
            end
`ifdef PATTERN_LOADER_READBACK_EN
            // Unpipelined: issue one read, then compare its data the next cycle.
            RB: begin
                busy_o = 1'b1;
                if (!rb_wait_q) begin
                    amm_if.read    = 1'b1;
                    amm_if.address = cnt_q;
                    if (accept) rb_wait_d = 1'b1;
                end else begin
                    mism_now  = mism_q | (amm_if.readdata != cur_word);
                    mism_d    = mism_now;
                    rb_wait_d = 1'b0;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d = '0;
                        if (mism_now) begin
                            error_d = 1'b1;
                            state_d = ERR;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + AMM_AWIDTH'(1);
                    end
                end
            end
`endif
            DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over any in-flight beat; ENA is then never issued.
        if (timeout) begin
            error_d = 1'b1;
            state_d = ERR;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            cnt_q     <= '0;
            error_q   <= 1'b0;
`ifdef PATTERN_LOADER_READBACK_EN
            rb_wait_q <= 1'b0;
            mism_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            cnt_q     <= cnt_d;
            error_q   <= error_d;
`ifdef PATTERN_LOADER_READBACK_EN
            rb_wait_q <= rb_wait_d;
            mism_q    <= mism_d;
`endif
        end
    end

endmodule

// File: tb/tb_pattern_loader.sv
// Directed bench for pattern_loader with a register-bank slave that can stall or corrupt readback.
// Outputs are logged per cycle at the falling edge, cycle 1 being the first cycle after accepted start.
module tb_pattern_loader;
    localparam int DW  = 32;
    localparam int AW  = 2;
    localparam int DEP = 4;
    localparam int TMO = 8;
`ifdef PATTERN_LOADER_READBACK_EN
    localparam int DONE_LAT = 12;
    localparam int N_RD     = 3;
`else
    localparam int DONE_LAT = 6;
    localparam int N_RD     = 0;
`endif
    localparam logic [95:0] PAT_A = 96'hA1B2C3D4_11223344_DEADBEEF;
    localparam logic [95:0] PAT_B = 96'h0BADF00D_CAFEBABE_55AA55AA;

    logic        clk = 1'b0;
    logic        srst_n = 1'b0;
    logic        start = 1'b0;
    logic [95:0] pattern = PAT_A;
    logic        busy, done, err;

    avalon_mm_if #(.AMM_DWIDTH(DW), .AMM_AWIDTH(AW)) amm ();

    pattern_loader #(
        .AMM_DWIDTH (DW),
        .REG_DEPTH  (DEP),
        .AMM_AWIDTH (AW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk_i     (clk),
        .srst_i    (srst_n),
        .start_i   (start),
        .pattern_i (pattern),
        .busy_o    (busy),
        .done_o    (done),
        .error_o   (err),
        .amm_if    (amm)
    );

    always #5 clk = ~clk;

    // Slave: register bank, write-only stall injection, optional corruption of word 2 readback.
    logic [31:0] mem [DEP];
    logic        stall_en = 1'b0;
    int          stall_addr = 0;
    int          stall_limit = 0;
    int          stall_used = 0;
    logic        corrupt = 1'b0;

    assign amm.waitrequest = amm.write && stall_en && (int'(amm.address) == stall_addr)
                             && (stall_used < stall_limit);

    always @(posedge clk) begin
        if (start) stall_used <= 0;
        else if (amm.waitrequest) stall_used <= stall_used + 1;
        if (amm.write && !amm.waitrequest) mem[amm.address] <= amm.writedata;
        if (amm.read && !amm.waitrequest)
            amm.readdata <= mem[amm.address] ^ ((corrupt && amm.address == 2'd2) ? 32'h1 : 32'h0);
    end

    int cyc = 0;
    int cyc0 = 0;
    bit rec = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    bit          lwr [32], lrd [32], lwt [32], lbusy [32], ldone [32], lerr [32];
    int          laddr [32];
    logic [31:0] ldata [32];

    always @(negedge clk) begin
        int k;
        k = cyc - cyc0;
        if (rec && k >= 0 && k < 32) begin
            lwr[k]   = amm.write;
            lrd[k]   = amm.read;
            lwt[k]   = amm.waitrequest;
            laddr[k] = int'(amm.address);
            ldata[k] = amm.writedata;
            lbusy[k] = busy;
            ldone[k] = done;
            lerr[k]  = err;
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        for (int k = 0; k < 32; k++) begin
            lwr[k] = 0; lrd[k] = 0; lwt[k] = 0; lbusy[k] = 0; ldone[k] = 0; lerr[k] = 0;
            laddr[k] = 0; ldata[k] = '0;
        end
    endtask

    // Pulses start for one cycle (or leaves it high) and anchors cycle numbering.
    task automatic launch(input bit hold);
        start = 1'b1;
        step(1);
        cyc0 = cyc - 1;
        clear_log();
        rec = 1'b1;
        if (!hold) start = 1'b0;
    endtask

    int          nb;
    int          bcyc [8];
    int          baddr [8];
    logic [31:0] bdata [8];

    task automatic collect_beats();
        nb = 0;
        for (int k = 1; k < 32; k++)
            if (lwr[k] && !lwt[k] && nb < 8) begin
                bcyc[nb] = k; baddr[nb] = laddr[k]; bdata[nb] = ldata[k];
                nb++;
            end
    endtask

    function automatic int first_done();
        for (int k = 1; k < 32; k++) if (ldone[k]) return k;
        return -1;
    endfunction

    function automatic int n_done();
        int n = 0;
        for (int k = 1; k < 32; k++) if (ldone[k]) n++;
        return n;
    endfunction

    function automatic int n_busy();
        int n = 0;
        for (int k = 1; k < 32; k++) if (lbusy[k]) n++;
        return n;
    endfunction

    function automatic int n_rd_beats();
        int n = 0;
        for (int k = 1; k < 32; k++) if (lrd[k] && !lwt[k]) n++;
        return n;
    endfunction

    function automatic int n_overlap();
        int n = 0;
        for (int k = 1; k < 32; k++) if (lrd[k] && lwr[k]) n++;
        return n;
    endfunction

    function automatic int n_wr_at(input int a, input int from);
        int n = 0;
        for (int k = from; k < 32; k++) if (lwr[k] && laddr[k] == a) n++;
        return n;
    endfunction

    int          exp_addr [5] = '{0, 1, 2, 3, 0};
    logic [31:0] exp_data [5] = '{32'h0, 32'hDEADBEEF, 32'h11223344, 32'hA1B2C3D4, 32'h1};
    int          n_en;

    initial begin
        // Reset state
        step(3);
        check("rst_write", amm.write, 0);
        check("rst_read", amm.read, 0);
        check("rst_addr", amm.address, 0);
        check("rst_wdata", amm.writedata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        srst_n = 1'b1;
        step(2);

        // Zero-wait sequence
        launch(0);
        step(20);
        collect_beats();
        check("t1_nbeats", nb, 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t1_addr%0d", i), baddr[i], exp_addr[i]);
            check($sformatf("t1_data%0d", i), bdata[i], exp_data[i]);
            check($sformatf("t1_cyc%0d", i), bcyc[i], i + 1);
        end
        check("t1_done_cyc", first_done(), DONE_LAT);
        check("t1_done_cnt", n_done(), 1);
        check("t1_busy_cnt", n_busy(), DONE_LAT);
        check("t1_busy_first", lbusy[1], 1);
        check("t1_busy_after", lbusy[DONE_LAT + 1], 0);
        check("t1_err", lerr[DONE_LAT + 1], 0);
        check("t1_rd_beats", n_rd_beats(), N_RD);
        check("t1_rw_overlap", n_overlap(), 0);

        // Three stall cycles on the address 2 write
        stall_en = 1'b1; stall_addr = 2; stall_limit = 3;
        launch(0);
        step(20);
        stall_en = 1'b0;
        collect_beats();
        check("t2_nbeats", nb, 5);
        check("t2_a2_cyc", bcyc[2], 6);
        check("t2_a2_data", bdata[2], 32'h11223344);
        check("t2_ena_cyc", bcyc[4], 8);
        check("t2_a2_wr_cycles", n_wr_at(2, 1), 4);
        check("t2_a2_stable", (ldata[3] == 32'h11223344) && (ldata[4] == 32'h11223344)
                              && (ldata[5] == 32'h11223344) && (ldata[6] == 32'h11223344), 1);
        check("t2_done_cyc", first_done(), DONE_LAT + 3);

        // Slave stuck on the address 1 write
        stall_en = 1'b1; stall_addr = 1; stall_limit = 1000;
        launch(0);
        step(16);
        stall_en = 1'b0;
        collect_beats();
        check("t3_a1_wr_cycles", n_wr_at(1, 1), TMO);
        check("t3_wr_dropped", lwr[10], 0);
        check("t3_err_set", lerr[10], 1);
        check("t3_busy_err", lbusy[10], 0);
        check("t3_err_sticky", lerr[16], 1);
        check("t3_nbeats", nb, 1);
        n_en = 0;
        for (int k = 1; k < 32; k++) if (lwr[k] && laddr[k] == 0 && ldata[k] == 32'h1) n_en++;
        check("t3_no_enable", n_en, 0);
        check("t3_done_cnt", n_done(), 0);
        check("t3_mem_ctrl", mem[0], 0);

        pattern = PAT_B;
        launch(0);
        step(DONE_LAT + 2);
        collect_beats();
        check("t3b_err_clr", lerr[1], 0);
        check("t3b_done_cyc", first_done(), DONE_LAT);
        check("t3b_a2_data", bdata[2], 32'hCAFEBABE);

        // start held high, then reset mid-PAT
        pattern = PAT_A;
        launch(1);
        pattern = PAT_B;
        step(2);
        srst_n = 1'b0;
        start = 1'b0;
        step(6);
        srst_n = 1'b1;
        step(3);
        collect_beats();
        check("t4_nbeats", nb, 3);
        check("t4_a1_addr", baddr[1], 1);
        check("t4_a1_data", bdata[1], 32'hDEADBEEF);
        check("t4_a2_data", bdata[2], 32'h11223344);
        check("t4_rst_write", lwr[4], 0);
        check("t4_rst_addr", laddr[4], 0);
        check("t4_rst_wdata", ldata[4], 0);
        check("t4_rst_busy", lbusy[4], 0);
        check("t4_rst_done", ldone[4], 0);
        check("t4_rst_err", lerr[4], 0);
        check("t4_no_more_wr", n_wr_at(0, 4) + n_wr_at(1, 4) + n_wr_at(2, 4) + n_wr_at(3, 4), 0);

`ifdef PATTERN_LOADER_READBACK_EN
        // Corrupted readback of word 2
        corrupt = 1'b1;
        launch(0);
        step(16);
        corrupt = 1'b0;
        check("t5_err", lerr[12], 1);
        check("t5_done_cnt", n_done(), 0);
        check("t5_rd_beats", n_rd_beats(), 3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
